// File: rtl/ad100_pkg.sv
// Shared definitions for the AD100 single-cycle CPU: opcodes, instruction
// field positions, reset vector and the boot ROM image.
package ad100_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_ADDI = 4'd7,
        OP_LUI  = 4'd8,
        OP_LW   = 4'd9,
        OP_SW   = 4'd10,
        OP_BEQ  = 4'd11,
        OP_BNE  = 4'd12,
        OP_JAL  = 4'd13,
        OP_SLT  = 4'd14,
        OP_HALT = 4'd15
    } opcode_e;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 24;
    localparam int RA_LSB  = 20;
    localparam int RB_LSB  = 16;
    localparam int IMM_LSB = 0;

    localparam logic [31:0] AD100_RESET_PC = 32'hFF00_0000;

    localparam int          ROM_WORDS    = 1024;
    localparam logic [31:0] ROM_LUI_R1   = 32'h8100_7000;
    localparam logic [31:0] ROM_ADDI_R2  = 32'h7200_00AD;
    localparam logic [31:0] ROM_SW_R2    = 32'hA210_0000;
    localparam logic [31:0] ROM_LW_R3    = 32'h9310_0000;
    localparam logic [31:0] ROM_HALT     = 32'hF000_0000;

    // Boot image: store 0xAD to the RAM base, read it back, then park.
    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        logic [31:0] word;
        case (idx)
            10'd0:   word = ROM_LUI_R1;
            10'd1:   word = ROM_ADDI_R2;
            10'd2:   word = ROM_SW_R2;
            10'd3:   word = ROM_LW_R3;
            default: word = ROM_HALT;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ad100_rom.sv
// Combinational 1024-word boot ROM holding the AD100 power-on program.
module ad100_rom
    import ad100_pkg::*;
(
    input  logic [9:0]  addr,
    output logic [31:0] read
);

    assign read = rom_word(addr);

endmodule

// File: rtl/ad100_cpu.sv
// AD100 single-cycle CPU: fetch, execute and retire one instruction per clock,
// with a 16-entry register file (r0 hardwired to zero) and a HALT state.
module ad100_cpu
    import ad100_pkg::*;
#(
    parameter logic [31:0] RESET_PC = AD100_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [29:0] addr_1,
    input  logic [31:0] read_1,
    output logic [29:0] addr_2,
    input  logic [31:0] read_2,
    output logic [31:0] write_2,
    output logic        write_enable_2
);

    logic [31:0] pc;
    logic        halted;
    logic [31:0] regs [0:15];

    opcode_e     op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;
    logic [31:0] sext;
    logic [31:0] rd_val;
    logic [31:0] ra_val;
    logic [31:0] rb_val;
    logic [31:0] eff_addr;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    logic [31:0] pc_next;
    logic        wb_en;
    logic [31:0] wb_val;
    logic        halt_next;

    assign op   = opcode_e'(read_1[OP_LSB +: 4]);
    assign rd   = read_1[RD_LSB +: 4];
    assign ra   = read_1[RA_LSB +: 4];
    assign rb   = read_1[RB_LSB +: 4];
    assign imm  = read_1[IMM_LSB +: 16];
    assign sext = {{16{imm[15]}}, imm};

    assign rd_val = (rd == 4'd0) ? 32'd0 : regs[rd];
    assign ra_val = (ra == 4'd0) ? 32'd0 : regs[ra];
    assign rb_val = (rb == 4'd0) ? 32'd0 : regs[rb];

    assign eff_addr      = ra_val + sext;
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {sext[29:0], 2'b00};

    assign addr_1         = pc[31:2];
    assign addr_2         = eff_addr[31:2];
    assign write_2        = rd_val;
    assign write_enable_2 = (op == OP_SW) && !halted && !reset;

    // Operands are read before the edge, so JAL rd==ra targets the old ra.
    always_comb begin
        pc_next   = pc_plus4;
        wb_en     = 1'b0;
        wb_val    = 32'd0;
        halt_next = halted;
        case (op)
            OP_ADD:  begin wb_en = 1'b1; wb_val = ra_val + rb_val; end
            OP_SUB:  begin wb_en = 1'b1; wb_val = ra_val - rb_val; end
            OP_AND:  begin wb_en = 1'b1; wb_val = ra_val & rb_val; end
            OP_OR:   begin wb_en = 1'b1; wb_val = ra_val | rb_val; end
            OP_XOR:  begin wb_en = 1'b1; wb_val = ra_val ^ rb_val; end
            OP_SHL:  begin wb_en = 1'b1; wb_val = ra_val << rb_val[4:0]; end
            OP_SHR:  begin wb_en = 1'b1; wb_val = ra_val >> rb_val[4:0]; end
            OP_ADDI: begin wb_en = 1'b1; wb_val = eff_addr; end
            OP_LUI:  begin wb_en = 1'b1; wb_val = {imm, 16'h0000}; end
            OP_LW:   begin wb_en = 1'b1; wb_val = read_2; end
            OP_SW:   ;
            OP_BEQ:  if (rd_val == ra_val) pc_next = branch_target;
            OP_BNE:  if (rd_val != ra_val) pc_next = branch_target;
            OP_JAL:  begin
                wb_en   = 1'b1;
                wb_val  = pc_plus4;
                pc_next = eff_addr & ~32'h3;
            end
            OP_SLT:  begin
                wb_en  = 1'b1;
                wb_val = ($signed(ra_val) < $signed(rb_val)) ? 32'd1 : 32'd0;
            end
            OP_HALT: begin pc_next = pc; halt_next = 1'b1; end
            default: ;
        endcase
        if (halted) begin
            pc_next = pc;
            wb_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            pc     <= pc_next;
            halted <= halt_next;
            if (wb_en && (rd != 4'd0)) begin
                regs[rd] <= wb_val;
            end
        end
    end

endmodule

// File: tb/tb_ad100_cpu.sv
// Directed testbench for ad100_cpu: boot ROM run, ALU/branch/jump programs
// and an asynchronous reset pulse in the middle of a store.
module tb_ad100_cpu;
    import ad100_pkg::*;

    logic        clk;
    logic        reset;
    logic [29:0] addr_1;
    logic [31:0] read_1;
    logic [29:0] addr_2;
    logic [31:0] read_2;
    logic [31:0] write_2;
    logic        write_enable_2;

    logic [31:0] rom_data;
    logic        use_rom;
    logic [31:0] prog [0:31];
    logic [31:0] alt  [0:31];
    logic [31:0] ram  [0:15];
    int          ram_writes;
    int          checks;
    int          failures;
    int          writes_before;

    ad100_cpu dut (
        .clk            (clk),
        .reset          (reset),
        .addr_1         (addr_1),
        .read_1         (read_1),
        .addr_2         (addr_2),
        .read_2         (read_2),
        .write_2        (write_2),
        .write_enable_2 (write_enable_2)
    );

    ad100_rom rom (
        .addr (addr_1[9:0]),
        .read (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM region (bit 29 of the word address set) serves prog, RAM region serves alt.
    assign read_1 = use_rom ? rom_data : (addr_1[29] ? prog[addr_1[4:0]] : alt[addr_1[4:0]]);
    assign read_2 = ram[addr_2[3:0]];

    always @(posedge clk) begin
        if (write_enable_2) begin
            ram[addr_2[3:0]] <= write_2;
            ram_writes       <= ram_writes + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_memories();
        for (int i = 0; i < 32; i++) begin
            prog[i] = 32'h0000_0000;
            alt[i]  = 32'h0000_0000;
        end
        for (int i = 0; i < 16; i++) begin
            ram[i] = 32'h0000_0000;
        end
    endtask

    // Hold reset across one edge, then release just after it so cycle 0 is word 0.
    task automatic apply_stimulus(input logic rom_sel);
        reset   = 1'b1;
        use_rom = rom_sel;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        ram_writes = 0;
        reset      = 1'b1;
        use_rom    = 1'b1;
        clear_memories();

        #1;
        check_output("reset_addr_1", {2'b00, addr_1}, 32'h3FC0_0000);
        check_output("reset_we", {31'd0, write_enable_2}, 32'd0);

        // Boot ROM run
        apply_stimulus(1'b1);
        check_output("boot_c0_fetch", read_1, 32'h8100_7000);
        tick();
        tick();
        check_output("boot_c2_we", {31'd0, write_enable_2}, 32'd1);
        check_output("boot_c2_addr_2", {2'b00, addr_2}, 32'h1C00_0000);
        check_output("boot_c2_write_2", write_2, 32'h0000_00AD);
        tick();
        check_output("boot_c3_load", read_2, 32'h0000_00AD);
        tick();
        check_output("boot_r3", dut.regs[3], 32'h0000_00AD);
        for (int i = 0; i < 3; i++) begin
            check_output("boot_halt_addr_1", {2'b00, addr_1}, 32'h3FC0_0004);
            check_output("boot_halt_we", {31'd0, write_enable_2}, 32'd0);
            tick();
        end

        // Program A: ALU corner cases, SLT, BNE not taken, LW, HALT
        prog[0]  = 32'h7000_0005;
        prog[1]  = 32'h0400_0000;
        prog[2]  = 32'hA400_0000;
        prog[3]  = 32'h7100_0001;
        prog[4]  = 32'h7200_0021;
        prog[5]  = 32'h5512_0000;
        prog[6]  = 32'hA500_0000;
        prog[7]  = 32'h1601_0000;
        prog[8]  = 32'hA600_0004;
        prog[9]  = 32'hE761_0000;
        prog[10] = 32'hA700_0000;
        prog[11] = 32'hC110_0005;
        prog[12] = 32'h9800_0004;
        prog[13] = 32'hA800_0000;
        prog[14] = 32'hF000_0000;
        apply_stimulus(1'b0);
        tick();
        tick();
        check_output("a_r4_zero", write_2, 32'h0000_0000);
        check_output("a_sw_we", {31'd0, write_enable_2}, 32'd1);
        tick();
        tick();
        tick();
        tick();
        check_output("a_shl_masked", write_2, 32'h0000_0002);
        tick();
        tick();
        check_output("a_sub_wrap", write_2, 32'hFFFF_FFFF);
        check_output("a_sw_addr_2", {2'b00, addr_2}, 32'h0000_0001);
        tick();
        tick();
        check_output("a_slt_signed", write_2, 32'h0000_0001);
        tick();
        check_output("a_bne_we", {31'd0, write_enable_2}, 32'd0);
        tick();
        check_output("a_bne_not_taken", {2'b00, addr_1}, 32'h3FC0_000C);
        check_output("a_lw_data", read_2, 32'hFFFF_FFFF);
        tick();
        check_output("a_lw_result", write_2, 32'hFFFF_FFFF);
        tick();
        check_output("a_halt_we", {31'd0, write_enable_2}, 32'd0);
        tick();
        tick();
        check_output("a_halt_pc", {2'b00, addr_1}, 32'h3FC0_000E);

        // Program B: BEQ not taken, JAL, JAL with rd == ra, BEQ self-loop
        clear_memories();
        prog[0] = 32'h8100_7000;
        prog[1] = 32'h7200_0003;
        prog[2] = 32'hB200_0007;
        prog[3] = 32'h0000_0000;
        prog[4] = 32'hDF10_0000;
        alt[0]  = 32'hAF00_0000;
        alt[1]  = 32'hD110_0008;
        alt[2]  = 32'hA100_0000;
        alt[3]  = 32'hB110_FFFF;
        apply_stimulus(1'b0);
        tick();
        tick();
        tick();
        check_output("b_beq_not_taken", {2'b00, addr_1}, 32'h3FC0_0003);
        tick();
        check_output("b_jal_pc", {2'b00, addr_1}, 32'h3FC0_0004);
        tick();
        check_output("b_jal_target", {2'b00, addr_1}, 32'h1C00_0000);
        check_output("b_jal_link", write_2, 32'hFF00_0014);
        tick();
        tick();
        check_output("b_jal_same_target", {2'b00, addr_1}, 32'h1C00_0002);
        check_output("b_jal_same_link", write_2, 32'h7000_0008);
        tick();
        check_output("b_beq_loop_pc", {2'b00, addr_1}, 32'h1C00_0003);
        tick();
        check_output("b_beq_loop_hold1", {2'b00, addr_1}, 32'h1C00_0003);
        tick();
        check_output("b_beq_loop_hold2", {2'b00, addr_1}, 32'h1C00_0003);

        // Asynchronous reset pulse while a store is on the bus
        clear_memories();
        prog[0] = 32'h7000_0005;
        prog[1] = 32'h0400_0000;
        prog[2] = 32'hA400_0000;
        apply_stimulus(1'b0);
        tick();
        tick();
        check_output("r_sw_we_before", {31'd0, write_enable_2}, 32'd1);
        writes_before = ram_writes;
        #1;
        reset = 1'b1;
        #1;
        check_output("r_pulse_we", {31'd0, write_enable_2}, 32'd0);
        check_output("r_pulse_addr_1", {2'b00, addr_1}, 32'h3FC0_0000);
        reset = 1'b0;
        tick();
        check_output("r_no_write", ram_writes, writes_before);
        check_output("r_restart_addr_1", {2'b00, addr_1}, 32'h3FC0_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
